// File: rtl/load_store_unit_pkg.sv
// Shared funct3 width/sign encodings and LSU FSM state encodings.
package load_store_unit_pkg;

   localparam int unsigned LSU_DATA_W = 32;
   localparam int unsigned LSU_ADDR_D = 8;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_RD   = 3'd1,
      LD_DATA = 3'd2,
      ST_WR   = 3'd3,
      RMW_RD  = 3'd4,
      RMW_MRG = 3'd5,
      RMW_WR  = 3'd6
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and word-memory port of the load/store unit.
interface load_store_unit_if #(
   parameter int unsigned W = 32,
   parameter int unsigned D = 8
);
   logic           i_req;
   logic           i_we;
   logic [2:0]     i_funct3;
   logic [D+1:0]   i_addr;
   logic [W-1:0]   i_wdata;
   logic           o_busy;
   logic           o_done;
   logic           o_misaligned;
   logic [W-1:0]   o_rdata;
   logic [D-1:0]   o_mem_addr;
   logic [W-1:0]   o_mem_data;
   logic           o_mem_read;
   logic           o_mem_write;
   logic [W-1:0]   i_mem_data;

   // LSU side
   modport slave (
      input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_data,
      output o_busy, o_done, o_misaligned, o_rdata,
             o_mem_addr, o_mem_data, o_mem_read, o_mem_write
   );

   // Core + memory side
   modport master (
      output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_data,
      input  o_busy, o_done, o_misaligned, o_rdata,
             o_mem_addr, o_mem_data, o_mem_read, o_mem_write
   );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
   import load_store_unit_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] word,
   input  logic [15:0]  wdata,
   input  logic [1:0]   lane,
   input  logic [2:0]   funct3,
   output logic [W-1:0] load_c,
   output logic [W-1:0] merge_c
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Select the addressed lane and extend it to a full word
   always_comb begin
      byte_v = word[{lane, 3'b000} +: 8];
      half_v = word[{lane[1], 4'b0000} +: 16];
      case (funct3)
         LSU_B:   load_c = {{(W-8){byte_v[7]}}, byte_v};
         LSU_H:   load_c = {{(W-16){half_v[15]}}, half_v};
         LSU_BU:  load_c = {{(W-8){1'b0}}, byte_v};
         LSU_HU:  load_c = {{(W-16){1'b0}}, half_v};
         default: load_c = word;
      endcase
   end

   // Replace the addressed lane of the old word with the store data
   always_comb begin
      merge_c = word;
      case (funct3)
         LSU_B:   merge_c[{lane, 3'b000} +: 8]     = wdata[7:0];
         LSU_H:   merge_c[{lane[1], 4'b0000} +: 16] = wdata;
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store unit over a word memory without byte enables.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned W = LSU_DATA_W,
   parameter int unsigned D = LSU_ADDR_D
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   load_store_unit_if.slave bus
);

   lsu_state_e   state;
   logic [2:0]   funct3_q;
   logic [1:0]   lane_q;
   logic [15:0]  wdata_q;
   logic         busy_q;
   logic         done_q;
   logic         mis_q;
   logic [W-1:0] rdata_q;
   logic [D-1:0] mem_addr_q;
   logic [W-1:0] mem_data_q;
   logic         mem_read_q;
   logic         mem_write_q;
   logic         reject_c;
   logic [W-1:0] load_c;
   logic [W-1:0] merge_c;

   lsu_lane_align #(.W(W)) u_align (
      .word    (bus.i_mem_data),
      .wdata   (wdata_q),
      .lane    (lane_q),
      .funct3  (funct3_q),
      .load_c  (load_c),
      .merge_c (merge_c)
   );

   // Alignment and encoding legality of the incoming request
   always_comb begin
      reject_c = 1'b0;
      case (bus.i_funct3)
         LSU_B:   reject_c = 1'b0;
         LSU_H:   reject_c = bus.i_addr[0];
         LSU_W:   reject_c = |bus.i_addr[1:0];
         LSU_BU:  reject_c = bus.i_we;
         LSU_HU:  reject_c = bus.i_we | bus.i_addr[0];
         default: reject_c = 1'b1;
      endcase
   end

   // Access sequencer; memory controls are registered alongside the state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         funct3_q    <= '0;
         lane_q      <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mis_q       <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         mis_q       <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req) begin
                  if (reject_c) begin
                     done_q <= 1'b1;
                     mis_q  <= 1'b1;
                  end else begin
                     funct3_q   <= bus.i_funct3;
                     lane_q     <= bus.i_addr[1:0];
                     wdata_q    <= bus.i_wdata[15:0];
                     mem_addr_q <= bus.i_addr[D+1:2];
                     busy_q     <= 1'b1;
                     if (!bus.i_we) begin
                        state      <= LD_RD;
                        mem_read_q <= 1'b1;
                     end else if (bus.i_funct3 == LSU_W) begin
                        state       <= ST_WR;
                        mem_write_q <= 1'b1;
                        mem_data_q  <= bus.i_wdata;
                     end else begin
                        state      <= RMW_RD;
                        mem_read_q <= 1'b1;
                     end
                  end
               end
            end
            LD_RD:   state <= LD_DATA;
            LD_DATA: begin
               rdata_q    <= load_c;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               mem_addr_q <= '0;
               state      <= IDLE;
            end
            RMW_RD:  state <= RMW_MRG;
            RMW_MRG: begin
               mem_data_q  <= merge_c;
               mem_write_q <= 1'b1;
               state       <= RMW_WR;
            end
            ST_WR, RMW_WR: begin
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               mem_addr_q <= '0;
               mem_data_q <= '0;
               state      <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_busy       = busy_q;
   assign bus.o_done       = done_q;
   assign bus.o_misaligned = mis_q;
   assign bus.o_rdata      = rdata_q;
   assign bus.o_mem_addr   = mem_addr_q;
   assign bus.o_mem_data   = mem_data_q;
   assign bus.o_mem_read   = mem_read_q;
   assign bus.o_mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and an expectation queue.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   typedef struct {
      string       tag;
      int          lat;
      logic        mis;
      logic [31:0] rd;
      int          rdn;
      int          wrn;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q[$];
   logic [31:0] mem [256];

   load_store_unit_if #(.W(32), .D(8)) bus ();

   load_store_unit #(.W(32), .D(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Word memory: write on o_mem_write, read data returned the following cycle
   always @(posedge clk) begin
      if (bus.o_mem_write) mem[bus.o_mem_addr] <= bus.o_mem_data;
      if (bus.o_mem_read) bus.i_mem_data <= mem[bus.o_mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request; expected outcome queued at drive time, checked when o_done pulses
   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [9:0] a, input logic [31:0] wd,
                         input bit exp_mis, input logic [31:0] exp_rd, input bit intrude);
      exp_t e;
      int   rdn = 0, wrn = 0, lat = 0, extra = 0;
      bit   got = 1'b0;
      e.tag = tag; e.mis = exp_mis; e.rd = exp_rd;
      if (exp_mis)           begin e.lat = 1; e.rdn = 0; e.wrn = 0; end
      else if (!we)          begin e.lat = 3; e.rdn = 1; e.wrn = 0; end
      else if (f3 == LSU_W)  begin e.lat = 2; e.rdn = 0; e.wrn = 1; end
      else                   begin e.lat = 4; e.rdn = 1; e.wrn = 1; end
      q.push_back(e);
      bus.i_req = 1'b1; bus.i_we = we; bus.i_funct3 = f3; bus.i_addr = a; bus.i_wdata = wd;
      @(posedge clk);
      for (int c = 1; c <= 12 && !got; c++) begin
         @(negedge clk);
         if (c == 1) bus.i_req = 1'b0;
         if (intrude && c == 2) begin
            bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_funct3 = LSU_W; bus.i_addr = '0;
         end
         if (intrude && c == 3) bus.i_req = 1'b0;
         if (bus.o_mem_read) rdn++;
         if (bus.o_mem_write) wrn++;
         if (c == 1 && !exp_mis && we && f3 == LSU_W) begin
            chk({tag, "/c1_write"}, 32'(bus.o_mem_write), 32'd1);
            chk({tag, "/c1_addr"}, 32'(bus.o_mem_addr), 32'(a[9:2]));
            chk({tag, "/c1_data"}, bus.o_mem_data, wd);
         end
         if (bus.o_done) begin got = 1'b1; lat = c; end
      end
      e = q.pop_front();
      if (!got) begin
         vectors++;
         miscompares++;
         $error("FAIL %s/timeout observed=no_done expected=done_in_%0d", e.tag, e.lat);
      end else begin
         chk({e.tag, "/lat"}, 32'(lat), 32'(e.lat));
         chk({e.tag, "/mis"}, 32'(bus.o_misaligned), 32'(e.mis));
         chk({e.tag, "/rdata"}, bus.o_rdata, e.rd);
         chk({e.tag, "/busy"}, 32'(bus.o_busy), 32'd0);
         chk({e.tag, "/reads"}, 32'(rdn), 32'(e.rdn));
         chk({e.tag, "/writes"}, 32'(wrn), 32'(e.wrn));
      end
      if (intrude) begin
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_mem_read) extra++;
         end
         chk({e.tag, "/ignored_req"}, 32'(extra), 32'd0);
      end
   endtask

   initial begin
      int wr = 0, dn = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = '0; bus.i_addr = '0; bus.i_wdata = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst/busy", 32'(bus.o_busy), 32'd0);
      chk("rst/done_mis", {30'd0, bus.o_done, bus.o_misaligned}, 32'd0);
      chk("rst/rdata", bus.o_rdata, 32'd0);
      chk("rst/mem_ctl", {22'd0, bus.o_mem_addr, bus.o_mem_read, bus.o_mem_write}, 32'd0);
      chk("rst/mem_data", bus.o_mem_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst/idle", 32'(bus.o_busy), 32'd0);

      // Word store then load
      access("sw10",  1'b1, LSU_W,  10'h010, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1'b0);
      chk("mem4_sw", mem[4], 32'hDEADBEEF);
      access("lw10",  1'b0, LSU_W,  10'h010, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
      access("sw10b", 1'b1, LSU_W,  10'h010, 32'h11223344, 1'b0, 32'hDEADBEEF, 1'b0);

      // Byte store and loads
      access("sb13",  1'b1, LSU_B,  10'h013, 32'h000000A5, 1'b0, 32'hDEADBEEF, 1'b0);
      chk("mem4_sb", mem[4], 32'hA5223344);
      access("lb13",  1'b0, LSU_B,  10'h013, 32'h0, 1'b0, 32'hFFFFFFA5, 1'b0);
      access("lbu13", 1'b0, LSU_BU, 10'h013, 32'h0, 1'b0, 32'h000000A5, 1'b0);
      access("lbu11", 1'b0, LSU_BU, 10'h011, 32'h0, 1'b0, 32'h00000033, 1'b0);

      // Half store and loads
      access("sh10",  1'b1, LSU_H,  10'h010, 32'h00008001, 1'b0, 32'h00000033, 1'b0);
      chk("mem4_sh", mem[4], 32'hA5228001);
      access("lh10",  1'b0, LSU_H,  10'h010, 32'h0, 1'b0, 32'hFFFF8001, 1'b0);
      access("lhu12", 1'b0, LSU_HU, 10'h012, 32'h0, 1'b0, 32'h0000A522, 1'b0);

      // Rejected requests
      access("rej_lw06", 1'b0, LSU_W,  10'h006, 32'h0, 1'b1, 32'h0000A522, 1'b0);
      access("rej_sh11", 1'b1, LSU_H,  10'h011, 32'h0000FFFF, 1'b1, 32'h0000A522, 1'b0);
      access("rej_f011", 1'b0, 3'b011, 10'h000, 32'h0, 1'b1, 32'h0000A522, 1'b0);
      access("rej_sbu",  1'b1, LSU_BU, 10'h010, 32'h0, 1'b1, 32'h0000A522, 1'b0);
      chk("mem4_rej", mem[4], 32'hA5228001);

      // Second request during read-modify-write is ignored
      access("sb12_busy", 1'b1, LSU_B, 10'h012, 32'h0000005A, 1'b0, 32'h0000A522, 1'b1);
      chk("mem4_sb12", mem[4], 32'hA55A8001);
      chk("mem0_untouched", mem[0], 32'h0);

      // Reset during the merge cycle drops the pending store
      bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = LSU_B;
      bus.i_addr = 10'h010; bus.i_wdata = 32'h00000077;
      @(posedge clk);
      @(negedge clk);
      bus.i_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.o_mem_write) wr++;
         if (bus.o_done) dn++;
      end
      chk("abort/busy", 32'(bus.o_busy), 32'd0);
      chk("abort/rdata", bus.o_rdata, 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.o_mem_write) wr++;
         if (bus.o_done) dn++;
      end
      chk("abort/writes", 32'(wr), 32'd0);
      chk("abort/done", 32'(dn), 32'd0);
      chk("abort/mem4", mem[4], 32'hA55A8001);

      // Unit still works after abort
      access("lw_post", 1'b0, LSU_W, 10'h010, 32'h0, 1'b0, 32'hA55A8001, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side load/store unit between the core's execute stage and the word-organised data `memory`. It accepts one byte-addressed load or store at a time, carrying RISC-V funct3 width/sign encodings. Each access becomes a word access on the memory port. Sub-word stores use read-modify-write, because the memory has no byte enables. Sub-word loads are extracted from the returned word and sign- or zero-extended.

## Interface
Parameters:
- `W`, 32, data/word width (fixed at 32 for RV32 lane logic)
- `D`, 8, memory word-address width; byte address is `D+2` bits

Ports:
- Reset is asynchronous, active-low.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_req`  in  1  request strobe; accepted only when `o_busy`=0
- `i_we`  in  1  1=store, 0=load
- `i_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- `i_addr`  in  D+2  byte address
- `i_wdata`  in  W  store data; low byte/half used for SB/SH
- `o_busy`  out  1  state≠IDLE
- `o_done`  out  1  one-cycle completion pulse
- `o_misaligned`  out  1  pulses with `o_done` on a rejected access
- `o_rdata`  out  W  extended load result; holds until the next load completes
- `o_mem_addr`  out  D  word address, `addr[D+1:2]`
- `o_mem_data`  out  W  write word
- `o_mem_read`  out  1  memory read enable
- `o_mem_write`  out  1  memory write enable
- `i_mem_data`  in  W  memory read word; valid the cycle after `o_mem_read`, held otherwise

## Operation
- **Accept.** On an edge with `i_req`=1 in IDLE, latch `i_we`, `i_funct3`, `i_addr` and `i_wdata`.
  - Requests while busy are ignored; there is no queue.
- **Reject.** A request is rejected if any of these holds:
  - H/HU with `addr[0]`=1
  - W with `addr[1:0]`≠0
  - funct3 ∈ {011,110,111}
  - store with funct3 ∈ {100,101}
  - A rejected request stays in IDLE and performs no memory access. `o_done`=`o_misaligned`=1 in the next cycle, and `o_rdata` is unchanged.
- **FSM states:** IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_MRG, RMW_WR.
  - Load: IDLE→LD_RD→LD_DATA→IDLE.
  - SW: IDLE→ST_WR→IDLE.
  - SB/SH: IDLE→RMW_RD→RMW_MRG→RMW_WR→IDLE.
- **Memory controls** are decoded from the state register.
  - `o_mem_read`=1 in LD_RD and RMW_RD.
  - `o_mem_write`=1 in ST_WR and RMW_WR.
  - `o_mem_addr` = latched word address in all non-IDLE states.
- **Load result.** Lanes are little-endian; the byte lane is `addr[1:0]`, the half lane is `addr[1]`.
  - In LD_DATA, the selected lane of `i_mem_data` is extended: B/H sign-extend, BU/HU zero-extend, W passes through.
  - The result is registered into `o_rdata`.
- **RMW merge.** In RMW_MRG, a merge register = `i_mem_data` with the selected lane replaced by `i_wdata[7:0]` or `i_wdata[15:0]`. `o_mem_data` = merge register in RMW_WR and latched `i_wdata` in ST_WR.
- **Completion.** `o_done` is registered: it pulses the cycle after LD_DATA, ST_WR or RMW_WR.
- **Address range.** The address cannot overflow: the word index is `addr[D+1:2]`.
- **Reset.** Asserting `i_rst_n`=0 at any time forces the following immediately:
  - State → IDLE; all outputs and internal registers → 0.
  - A pending store is dropped: no `o_mem_write` and no `o_done`.
  - Memory contents are unaffected.

## Timing
- Cycle 0 is the cycle in which the request is sampled.
- **LW/LB/LH/LBU/LHU:**
  - `o_mem_read` in cycle 1.
  - `i_mem_data` is used in cycle 2.
  - `o_done` and `o_rdata` are valid in cycle 3.
- **SW:** `o_mem_write` in cycle 1; `o_done` in cycle 2.
- **SB/SH:** read in cycle 1, merge in cycle 2, write in cycle 3, `o_done` in cycle 4.
- **Reject:** `o_done` and `o_misaligned` in cycle 1.
- `o_busy` falls in the `o_done` cycle, so a new request may be accepted in that same cycle (back-to-back throughput).

## Structure
- **Shared package/header:** funct3 encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and FSM state encodings. Both are shared with decode and with the testbench.
- **Sub-module `lsu_lane_align`** (combinational), which provides:
  - load extract/extend from (word, `addr[1:0]`, funct3)
  - store merge from (old word, wdata, `addr[1:0]`, funct3)
- The top level holds the FSM, the latches and the output registers.

## Test plan
1. **Reset values:** hold `i_rst_n`=0 → all outputs 0 and `o_busy`=0. Release it → IDLE.
2. **SW then LW:**
   - SW `addr`=0x010, `wdata`=0xDEADBEEF → cycle 1 `o_mem_write`=1, `o_mem_addr`=0x04, data 0xDEADBEEF; `o_done` in cycle 2.
   - LW 0x010 → `o_rdata`=0xDEADBEEF with `o_done` in cycle 3.
3. **SB and byte loads:** memory word 0x04=0x11223344.
   - SB 0x013 with `wdata`=0x000000A5 → word becomes 0xA5223344; `o_done` in cycle 4.
   - LB 0x013 → 0xFFFFFFA5; LBU 0x013 → 0x000000A5.
4. **SH and half load:** SH 0x010 with `wdata`=0x00008001 over 0xA5223344 → word becomes 0xA5228001. LH 0x010 → 0xFFFF8001; LHU 0x012 → 0x0000A522.
5. **Rejects:** LW 0x006, SH 0x011, funct3=011 → each gives `o_done`=`o_misaligned`=1 in cycle 1. `o_mem_read`/`o_mem_write` never assert, and `o_rdata` is unchanged.
6. **Busy and reset abort:**
   - A second `i_req` during RMW is ignored.
   - Reset asserted in RMW_MRG → `o_mem_write` never asserts, the word is unchanged and `o_done` never pulses.
